// File: rtl/eq_gain_mixer_pkg.sv
// Shared equalizer definitions: mixer FSM states, gain/accumulator sizing
// helpers and the saturating clamp used across the equalizer blocks.
package eq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } mix_state_t;

    function automatic int unity_gain(input int gain_frac);
        return 1 << gain_frac;
    endfunction

    // Wide enough to sum NUM_BANDS full-scale products without overflow.
    function automatic int acc_width(input int data_w, input int gain_w, input int num_bands);
        return data_w + gain_w + $clog2(num_bands) + 1;
    endfunction

    function automatic logic signed [63:0] saturate(input logic signed [63:0] x, input int data_w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (data_w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (data_w - 1));
        if (x > hi) begin
            return hi;
        end else if (x < lo) begin
            return lo;
        end
        return x;
    endfunction

endpackage

// File: rtl/eq_gain_mixer_if.sv
// Sample-in / mix-out handshake bundle for the equalizer gain mixer.
// The master drives samples and output acceptance; the slave is the mixer.
interface eq_gain_mixer_if #(
    parameter int NUM_BANDS = 4,
    parameter int DATA_W    = 16,
    parameter int GAIN_W    = 8
);
    logic                          in_valid;
    logic                          in_ready;
    logic [NUM_BANDS*DATA_W-1:0]   band_in;
    logic [NUM_BANDS*GAIN_W-1:0]   gain_target;
    logic                          bypass;
    logic                          out_valid;
    logic                          out_ready;
    logic [DATA_W-1:0]             audio_out;
    logic                          clip;

    modport master (
        output in_valid, band_in, gain_target, bypass, out_ready,
        input  in_ready, out_valid, audio_out, clip
    );

    modport slave (
        input  in_valid, band_in, gain_target, bypass, out_ready,
        output in_ready, out_valid, audio_out, clip
    );
endinterface

// File: rtl/eq_gain_mixer_gain_ramp.sv
// Per-band gain slew limiter: on each update strobe the gain moves toward
// its target by at most RAMP_STEP, landing exactly on the target.
module gain_ramp
    import eq_pkg::*;
#(
    parameter int GAIN_W    = 8,
    parameter int GAIN_FRAC = 5,
    parameter int RAMP_STEP = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_update,
    input  logic [GAIN_W-1:0] i_target,
    output logic [GAIN_W-1:0] o_gain
);
    localparam logic [GAIN_W-1:0] UNITY = GAIN_W'(unity_gain(GAIN_FRAC));
    localparam logic [GAIN_W-1:0] STEP  = GAIN_W'(RAMP_STEP);

    logic [GAIN_W-1:0] r_gain;
    logic [GAIN_W-1:0] w_gain_next;

    always_comb begin
        w_gain_next = r_gain;
        if (i_target > r_gain) begin
            w_gain_next = ((i_target - r_gain) > STEP) ? (r_gain + STEP) : i_target;
        end else if (i_target < r_gain) begin
            w_gain_next = ((r_gain - i_target) > STEP) ? (r_gain - STEP) : i_target;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gain <= UNITY;
        end else if (i_update) begin
            r_gain <= w_gain_next;
        end
    end

    assign o_gain = r_gain;

endmodule

// File: rtl/eq_gain_mixer.sv
// N-band gain-and-mix stage: one band per cycle through a shared multiplier,
// ramped per-band gains, saturated band sum presented with valid/ready.
module eq_gain_mixer
    import eq_pkg::*;
#(
    parameter int NUM_BANDS = 4,
    parameter int DATA_W    = 16,
    parameter int GAIN_W    = 8,
    parameter int GAIN_FRAC = 5,
    parameter int RAMP_STEP = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    eq_gain_mixer_if.slave bus
);
    localparam int ACC_W  = acc_width(DATA_W, GAIN_W, NUM_BANDS);
    localparam int PROD_W = DATA_W + GAIN_W + 1;
    localparam int IDX_W  = $clog2(NUM_BANDS);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_BANDS - 1);
    localparam logic [GAIN_W-1:0] UNITY    = GAIN_W'(unity_gain(GAIN_FRAC));

    mix_state_t               r_state;
    logic signed [DATA_W-1:0] r_band [NUM_BANDS];
    logic                     r_bypass;
    logic signed [ACC_W-1:0]  r_acc;
    logic [IDX_W-1:0]         r_idx;
    logic [DATA_W-1:0]        r_audio;
    logic                     r_clip;

    logic [GAIN_W-1:0]        w_gain_cur [NUM_BANDS];
    logic                     w_accept;
    logic [GAIN_W-1:0]        w_gain_sel;
    logic signed [PROD_W-1:0] w_prod;
    logic signed [ACC_W-1:0]  w_acc_sum;
    logic signed [ACC_W-1:0]  w_acc_shr;
    logic signed [63:0]       w_sat;
    logic                     w_clip;

    assign w_accept = (r_state == IDLE) && bus.in_valid;

    // Gains advance only on accepted samples, so the MAC sees the post-ramp value.
    generate
        for (genvar gi = 0; gi < NUM_BANDS; gi++) begin : g_band
            gain_ramp #(
                .GAIN_W    (GAIN_W),
                .GAIN_FRAC (GAIN_FRAC),
                .RAMP_STEP (RAMP_STEP)
            ) u_ramp (
                .clk      (clk),
                .rst_n    (rst_n),
                .i_update (w_accept),
                .i_target (bus.gain_target[gi*GAIN_W +: GAIN_W]),
                .o_gain   (w_gain_cur[gi])
            );
        end
    endgenerate

    // Gain is zero-extended so the unsigned value survives the signed multiply.
    assign w_gain_sel = r_bypass ? UNITY : w_gain_cur[r_idx];
    assign w_prod     = r_band[r_idx] * $signed({1'b0, w_gain_sel});
    assign w_acc_sum  = r_acc + ACC_W'(w_prod);
    assign w_acc_shr  = w_acc_sum >>> GAIN_FRAC;
    assign w_sat      = saturate(64'(w_acc_shr), DATA_W);
    assign w_clip     = (w_sat != 64'(w_acc_shr));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_bypass <= 1'b0;
            r_acc    <= '0;
            r_idx    <= '0;
            r_audio  <= '0;
            r_clip   <= 1'b0;
            for (int b = 0; b < NUM_BANDS; b++) begin
                r_band[b] <= '0;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        for (int b = 0; b < NUM_BANDS; b++) begin
                            r_band[b] <= bus.band_in[b*DATA_W +: DATA_W];
                        end
                        r_bypass <= bus.bypass;
                        r_acc    <= '0;
                        r_idx    <= '0;
                        r_state  <= MAC;
                    end
                end
                MAC: begin
                    r_acc <= w_acc_sum;
                    r_idx <= r_idx + 1'b1;
                    // Final band: latch the saturated result so it is stable through OUT.
                    if (r_idx == LAST_IDX) begin
                        r_audio <= w_sat[DATA_W-1:0];
                        r_clip  <= w_clip;
                        r_state <= OUT;
                    end
                end
                OUT: begin
                    if (bus.out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (r_state == IDLE);
    assign bus.out_valid = (r_state == OUT);
    assign bus.audio_out = r_audio;
    assign bus.clip      = r_clip;

endmodule
